process_element_mac_pipe: RTL and testbench
===========================================

// Module: process_element_mac_pipe
// PURPOSE
//  Parametrised signed multiply-accumulate pipeline for the process element datapath.
//  Generalises the fixed 16s x 8s -> 24 DSP multiplier with configurable widths and stage count,
//  an input valid, a per-beat mode (multiply / accumulate), group termination via last,
//  and optional saturation with overflow flag. Sits between the operand fetch and writeback in process_element.
// PARAMETERS
//  DIN0_WIDTH  16  signed width of din0
//  DIN1_WIDTH  8   signed width of din1
//  MUL_STAGES  4   multiply pipeline depth, >=2 (input reg + product reg + MUL_STAGES-2 retime regs)
//  ACC_WIDTH   32  accumulator/output width; must be >= DIN0_WIDTH+DIN1_WIDTH
//  SATURATE    1   1: clamp accumulation to signed ACC_WIDTH range; 0: two's-complement wrap
// PORTS
//  clk       in   1           clock, all state on rising edge
//  reset     in   1           synchronous, active-low reset (reset==0 resets at the edge)
//  ce        in   1           clock enable; 0 freezes the entire pipeline
//  in_valid  in   1           beat present on din0/din1/in_mode/in_last
//  din0      in   DIN0_WIDTH  signed operand A
//  din1      in   DIN1_WIDTH  signed operand B
//  in_mode   in   1           0 = multiply (product out per beat), 1 = accumulate
//  in_last   in   1           closes accumulation group (ignored when in_mode=0)
//  out_valid out  1           one-cycle pulse per result
//  dout      out  ACC_WIDTH   signed result
//  ovf       out  1           saturation/wrap occurred in the reported group
// BEHAVIOUR
//  - Reset: out_valid=0, dout=0, ovf=0; all stage valids, accumulator and sticky ovf cleared.
//  - Beat accepted at an edge where ce=1 and in_valid=1; mode/last travel as sideband with it.
//  - Latency: result registered MUL_STAGES+1 ce-enabled edges after acceptance (5 by default).
//  - ce=0: no register advances except out_valid, which clears to 0 at that edge; dout/ovf hold.
//    Hence exactly one out_valid pulse per result regardless of stalls.
//  - Product P = din0*din1, full width DIN0_WIDTH+DIN1_WIDTH, sign-extended to ACC_WIDTH.
//  - Mode 0 beat: dout=P, ovf=0, out_valid=1; any open accumulation group is discarded.
//  - Mode 1 beat: sum = (group open ? acc : 0) + P, computed at ACC_WIDTH+1 bits.
//    Overflow if sum outside signed ACC_WIDTH range; SATURATE=1 -> clamp to max/min, else wrap.
//    Overflow sets sticky flag for the group. Not last: acc<=sum, group open, no output.
//    Last: dout=sum, ovf=sticky|this overflow, out_valid=1; group closes, sticky cleared.
//  - Back-to-back groups: beat following a last starts a fresh group, no bubble required.
//  - Invalid beats (in_valid=0) occupy stages as bubbles; accumulator untouched.
//  - Reset mid-group: partial sum and in-flight beats discarded; no out_valid for them.
// STRUCTURE
//  - Package process_element_pkg: mode constants (PE_MODE_MUL=1'b0, PE_MODE_ACC=1'b1),
//    function sat_signed(value, width) returning clamped value and overflow bit.
//  - Sub-module process_element_mul_pipe: MUL_STAGES-deep signed multiplier with valid,
//    mode and last sideband shift register, ce-gated. Top holds accumulator, sticky ovf, output regs.
// TESTING (defaults unless stated; ce=1 unless stated)
//  1 Mode 0: din0=-300, din1=7 -> 5 edges later out_valid pulse 1 cycle, dout=-2100, ovf=0.
//  2 Mode 1 beats (100,2),(-50,3),(1000,-1),(7,7 last) -> single pulse dout=-901, ovf=0.
//  3 ACC_WIDTH=24: 3x(-32768,-128) last on 3rd -> SATURATE=1: dout=8388607, ovf=1;
//    SATURATE=0: dout=-4194304, ovf=1.
//  4 Stream of 6 mode-0 beats with ce low for 3 cycles mid-stream -> 6 pulses, correct order, no dup.
//  5 Mode 1 (3,3),(4,4), reset=0 for 1 cycle, then (5,5 last) -> one pulse dout=25, ovf=0.
//  6 Back-to-back: (2,2 last),(3,3 last) consecutive -> pulses on consecutive cycles dout=4 then 9.

Source files
------------

// File: rtl/process_element_pkg.sv
// Shared definitions for the process element datapath.
//  - pe_mode_e  : per-beat operation selector (multiply or accumulate)
//  - sat_signed : clamps a wide signed value into a signed field of a given
//                 width and reports whether clamping was needed
package process_element_pkg;

  typedef enum logic {
    PE_MODE_MUL = 1'b0,
    PE_MODE_ACC = 1'b1
  } pe_mode_e;

  // Widest accumulator the saturation helper can serve
  localparam int unsigned PE_SAT_MAX_WIDTH = 64;

  // Clamp 'value' to the signed range of 'width' bits. 'ovf' is raised when
  // the value lies outside that range. The result is returned at full helper
  // width; callers truncate to their own width.
  function automatic logic signed [PE_SAT_MAX_WIDTH:0] sat_signed(
    input  logic signed [PE_SAT_MAX_WIDTH:0] value,
    input  int unsigned                      width,
    output logic                             ovf
  );
    logic signed [PE_SAT_MAX_WIDTH:0] max_v;
    logic signed [PE_SAT_MAX_WIDTH:0] min_v;
    logic signed [PE_SAT_MAX_WIDTH:0] res_v;
    max_v = (65'sd1 <<< (width - 32'd1)) - 65'sd1;
    min_v = -(65'sd1 <<< (width - 32'd1));
    if (value > max_v) begin
      res_v = max_v;
      ovf   = 1'b1;
    end else if (value < min_v) begin
      res_v = min_v;
      ovf   = 1'b1;
    end else begin
      res_v = value;
      ovf   = 1'b0;
    end
    return res_v;
  endfunction

endpackage

// File: rtl/process_element_mul_pipe.sv
// MUL_STAGES-deep signed multiplier with valid/mode/last sideband.
//  Stage 0 registers the operands, stage 1 registers the full-width product,
//  stages 2..MUL_STAGES-1 are plain retiming registers. Everything advances
//  only when ce=1; reset (active-low, synchronous) clears all stages.
// Ports:
//  clk, reset, ce         clock, sync active-low reset, clock enable
//  in_valid/in_mode/in_last, din0, din1   incoming beat
//  p_valid/p_mode/p_last, p               beat leaving the last stage
module process_element_mul_pipe
  import process_element_pkg::*;
#(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 8,
  parameter int MUL_STAGES = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   ce,
  input  logic                                   in_valid,
  input  logic signed [DIN0_WIDTH-1:0]           din0,
  input  logic signed [DIN1_WIDTH-1:0]           din1,
  input  logic                                   in_mode,
  input  logic                                   in_last,
  output logic                                   p_valid,
  output logic signed [DIN0_WIDTH+DIN1_WIDTH-1:0] p,
  output logic                                   p_mode,
  output logic                                   p_last
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

  logic signed [DIN0_WIDTH-1:0] a_r;
  logic signed [DIN1_WIDTH-1:0] b_r;
  logic signed [PW-1:0]         a_ext_s;
  logic signed [PW-1:0]         b_ext_s;
  logic signed [PW-1:0]         prod_s;
  logic signed [PW-1:0]         prod_r [MUL_STAGES-1];
  logic [MUL_STAGES-1:0]        valid_r;
  logic [MUL_STAGES-1:0]        mode_r;
  logic [MUL_STAGES-1:0]        last_r;

  // Sign-extend operands to product width so the multiply is exact
  always_comb begin
    a_ext_s = {{DIN1_WIDTH{a_r[DIN0_WIDTH-1]}}, a_r};
    b_ext_s = {{DIN0_WIDTH{b_r[DIN1_WIDTH-1]}}, b_r};
    prod_s  = a_ext_s * b_ext_s;
  end

  // Operand, product and retime registers plus sideband shift chain
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_r     <= {DIN0_WIDTH{1'b0}};
      b_r     <= {DIN1_WIDTH{1'b0}};
      valid_r <= {MUL_STAGES{1'b0}};
      mode_r  <= {MUL_STAGES{1'b0}};
      last_r  <= {MUL_STAGES{1'b0}};
      for (int i = 0; i < MUL_STAGES - 1; i++) begin
        prod_r[i] <= {PW{1'b0}};
      end
    end else if (ce) begin
      a_r       <= din0;
      b_r       <= din1;
      valid_r   <= {valid_r[MUL_STAGES-2:0], in_valid};
      mode_r    <= {mode_r[MUL_STAGES-2:0], in_mode};
      last_r    <= {last_r[MUL_STAGES-2:0], in_last};
      prod_r[0] <= prod_s;
      for (int i = 1; i < MUL_STAGES - 1; i++) begin
        prod_r[i] <= prod_r[i-1];
      end
    end
  end

  assign p_valid = valid_r[MUL_STAGES-1];
  assign p_mode  = mode_r[MUL_STAGES-1];
  assign p_last  = last_r[MUL_STAGES-1];
  assign p       = prod_r[MUL_STAGES-2];

endmodule

// File: rtl/process_element_mac_pipe.sv
// Signed multiply-accumulate pipeline for the process element datapath.
//  Products come from process_element_mul_pipe; this level owns the
//  accumulator, the group-open flag, the sticky overflow flag and the
//  registered outputs. Result appears MUL_STAGES+1 enabled edges after the
//  beat is accepted (the acceptance edge counts as the first).
// Ports:
//  clk       clock, all state on rising edge
//  reset     synchronous active-low reset
//  ce        clock enable; 0 freezes everything except out_valid (clears)
//  in_valid  beat present on din0/din1/in_mode/in_last
//  din0/din1 signed operands
//  in_mode   0 multiply, 1 accumulate
//  in_last   closes an accumulation group
//  out_valid one-cycle pulse per result
//  dout      signed result
//  ovf       saturation/wrap seen in the reported group
module process_element_mac_pipe
  import process_element_pkg::*;
#(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 8,
  parameter int MUL_STAGES = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int SATURATE   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  input  logic                         in_mode,
  input  logic                         in_last,
  output logic                         out_valid,
  output logic signed [ACC_WIDTH-1:0]  dout,
  output logic                         ovf
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

  logic                        mul_valid_s;
  logic signed [PW-1:0]        mul_p_s;
  logic                        mul_mode_s;
  logic                        mul_last_s;

  logic signed [ACC_WIDTH-1:0] p_ext_s;
  logic signed [ACC_WIDTH-1:0] base_s;
  logic signed [ACC_WIDTH:0]   sum_s;
  logic signed [ACC_WIDTH-1:0] acc_sat_s;
  logic signed [ACC_WIDTH-1:0] acc_next_s;
  logic                        sat_ovf_s;

  logic signed [ACC_WIDTH-1:0] acc_r;
  logic                        group_open_r;
  logic                        sticky_r;
  logic                        out_valid_r;
  logic signed [ACC_WIDTH-1:0] dout_r;
  logic                        ovf_r;

  process_element_mul_pipe #(
    .DIN0_WIDTH (DIN0_WIDTH),
    .DIN1_WIDTH (DIN1_WIDTH),
    .MUL_STAGES (MUL_STAGES)
  ) u_mul (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .in_valid (in_valid),
    .din0     (din0),
    .din1     (din1),
    .in_mode  (in_mode),
    .in_last  (in_last),
    .p_valid  (mul_valid_s),
    .p        (mul_p_s),
    .p_mode   (mul_mode_s),
    .p_last   (mul_last_s)
  );

  // Accumulate path: one extra bit on the sum exposes any overflow
  always_comb begin
    sat_ovf_s = 1'b0;
    p_ext_s   = ACC_WIDTH'(mul_p_s);
    if (group_open_r) begin
      base_s = acc_r;
    end else begin
      base_s = {ACC_WIDTH{1'b0}};
    end
    sum_s     = (ACC_WIDTH+1)'(base_s) + (ACC_WIDTH+1)'(p_ext_s);
    acc_sat_s = ACC_WIDTH'(sat_signed(65'(sum_s), ACC_WIDTH, sat_ovf_s));
    if (SATURATE != 0) begin
      acc_next_s = acc_sat_s;
    end else begin
      acc_next_s = sum_s[ACC_WIDTH-1:0];
    end
  end

  // Accumulator, group tracking and registered result
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_r        <= {ACC_WIDTH{1'b0}};
      group_open_r <= 1'b0;
      sticky_r     <= 1'b0;
      out_valid_r  <= 1'b0;
      dout_r       <= {ACC_WIDTH{1'b0}};
      ovf_r        <= 1'b0;
    end else if (!ce) begin
      // Stalled: the pulse must not repeat, everything else holds
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      if (mul_valid_s) begin
        if (mul_mode_s == PE_MODE_MUL) begin
          // Plain product; any open group is abandoned
          dout_r       <= p_ext_s;
          ovf_r        <= 1'b0;
          out_valid_r  <= 1'b1;
          acc_r        <= {ACC_WIDTH{1'b0}};
          group_open_r <= 1'b0;
          sticky_r     <= 1'b0;
        end else if (mul_last_s) begin
          dout_r       <= acc_next_s;
          ovf_r        <= sticky_r | sat_ovf_s;
          out_valid_r  <= 1'b1;
          group_open_r <= 1'b0;
          sticky_r     <= 1'b0;
        end else begin
          acc_r        <= acc_next_s;
          group_open_r <= 1'b1;
          sticky_r     <= sticky_r | sat_ovf_s;
        end
      end
    end
  end

  assign out_valid = out_valid_r;
  assign dout      = dout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_process_element_mac_pipe.sv
// Scoreboard bench for process_element_mac_pipe. Three instances share the
// stimulus: default (32-bit acc, saturating), 24-bit saturating and 24-bit
// wrapping. The driver pushes expected results per instance; a monitor on the
// falling edge pops and compares whenever an instance pulses out_valid.
module tb_process_element_mac_pipe;

  typedef struct {
    logic signed [31:0] d;
    logic               o;
    int                 cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               ce;
  logic               in_valid;
  logic signed [15:0] din0;
  logic signed [7:0]  din1;
  logic               in_mode;
  logic               in_last;

  logic               ov0, ov1, ov2;
  logic signed [31:0] dout0;
  logic signed [23:0] dout1, dout2;
  logic               of0, of1, of2;

  exp_t sb_q [3][$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  process_element_mac_pipe #(.ACC_WIDTH(32), .SATURATE(1)) dut0 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .in_mode(in_mode), .in_last(in_last), .out_valid(ov0), .dout(dout0), .ovf(of0));

  process_element_mac_pipe #(.ACC_WIDTH(24), .SATURATE(1)) dut1 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .in_mode(in_mode), .in_last(in_last), .out_valid(ov1), .dout(dout1), .ovf(of1));

  process_element_mac_pipe #(.ACC_WIDTH(24), .SATURATE(0)) dut2 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .in_mode(in_mode), .in_last(in_last), .out_valid(ov2), .dout(dout2), .ovf(of2));

  task automatic chk(input int k, input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL dut%0d %s: got %0d expected %0d (t=%0t)", k, name, got, exp, $time);
    end
  endtask

  task automatic mon(input int k, input logic v, input logic signed [31:0] d, input logic o);
    exp_t e;
    if (v === 1'b1) begin
      if (sb_q[k].size() == 0) begin
        n_checks++;
        $display("FAIL dut%0d unexpected_pulse: got dout %0d expected no result (t=%0t)", k, d, $time);
      end else begin
        e = sb_q[k].pop_front();
        chk(k, "dout", d, e.d);
        chk(k, "ovf", o, e.o);
        if (e.cyc >= 0) chk(k, "latency", cyc, e.cyc);
      end
    end
  endtask

  // Monitor: compare every presented result against the scoreboard
  always @(negedge clk) begin
    mon(0, ov0, dout0, of0);
    mon(1, ov1, {{8{dout1[23]}}, dout1}, of1);
    mon(2, ov2, {{8{dout2[23]}}, dout2}, of2);
  end

  task automatic beat(input logic signed [15:0] a, input logic signed [7:0] b,
                      input logic mode, input logic last, input logic exp_out,
                      input logic signed [31:0] e0, input logic signed [31:0] e1,
                      input logic signed [31:0] e2, input logic o0, input logic o1,
                      input logic o2, input logic timed);
    exp_t e;
    @(negedge clk);
    ce = 1'b1; in_valid = 1'b1; din0 = a; din1 = b; in_mode = mode; in_last = last;
    if (exp_out) begin
      e.cyc = timed ? cyc + 5 : -1;
      e.d = e0; e.o = o0; sb_q[0].push_back(e);
      e.d = e1; e.o = o1; sb_q[1].push_back(e);
      e.d = e2; e.o = o2; sb_q[2].push_back(e);
    end
  endtask

  task automatic beat_all(input logic signed [15:0] a, input logic signed [7:0] b,
                          input logic mode, input logic last, input logic exp_out,
                          input logic signed [31:0] e, input logic timed);
    beat(a, b, mode, last, exp_out, e, e, e, 1'b0, 1'b0, 1'b0, timed);
  endtask

  // Idle cycles; with ce_v=0 a garbage beat is offered that must be ignored
  task automatic idle(input int n, input logic ce_v, input logic v_v);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ce = ce_v; in_valid = v_v; din0 = 16'sd1234; din1 = 8'sd55;
      in_mode = 1'b0; in_last = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b0; ce = 1'b0; in_valid = 1'b0; din0 = 16'sd0; din1 = 8'sd0;
    in_mode = 1'b0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(0, "reset_out_valid", ov0, 0); chk(0, "reset_dout", dout0, 0); chk(0, "reset_ovf", of0, 0);
    chk(1, "reset_out_valid", ov1, 0); chk(1, "reset_dout", dout1, 0); chk(1, "reset_ovf", of1, 0);
    chk(2, "reset_out_valid", ov2, 0); chk(2, "reset_dout", dout2, 0); chk(2, "reset_ovf", of2, 0);
    reset = 1'b1; ce = 1'b1;
    idle(2, 1'b1, 1'b0);

    // Single multiply
    beat_all(-16'sd300, 8'sd7, 1'b0, 1'b0, 1'b1, -32'sd2100, 1'b1);
    idle(8, 1'b1, 1'b0);

    // Four-beat accumulation group
    beat_all(16'sd100, 8'sd2, 1'b1, 1'b0, 1'b0, 32'sd0, 1'b0);
    beat_all(-16'sd50, 8'sd3, 1'b1, 1'b0, 1'b0, 32'sd0, 1'b0);
    beat_all(16'sd1000, -8'sd1, 1'b1, 1'b0, 1'b0, 32'sd0, 1'b0);
    beat_all(16'sd7, 8'sd7, 1'b1, 1'b1, 1'b1, -32'sd901, 1'b1);
    idle(8, 1'b1, 1'b0);

    // Overflow group: 3 x 2^22; then back-to-back single-beat groups
    beat_all(-16'sd32768, -8'sd128, 1'b1, 1'b0, 1'b0, 32'sd0, 1'b0);
    beat_all(-16'sd32768, -8'sd128, 1'b1, 1'b0, 1'b0, 32'sd0, 1'b0);
    beat(-16'sd32768, -8'sd128, 1'b1, 1'b1, 1'b1,
         32'sd12582912, 32'sd8388607, -32'sd4194304, 1'b0, 1'b1, 1'b1, 1'b1);
    beat_all(16'sd2, 8'sd2, 1'b1, 1'b1, 1'b1, 32'sd4, 1'b1);
    beat_all(16'sd3, 8'sd3, 1'b1, 1'b1, 1'b1, 32'sd9, 1'b1);
    idle(8, 1'b1, 1'b0);

    // Multiply beat discards an open group
    beat_all(16'sd10, 8'sd10, 1'b1, 1'b0, 1'b0, 32'sd0, 1'b0);
    beat_all(16'sd2, 8'sd3, 1'b0, 1'b0, 1'b1, 32'sd6, 1'b1);
    beat_all(16'sd1, 8'sd1, 1'b1, 1'b1, 1'b1, 32'sd1, 1'b1);
    idle(8, 1'b1, 1'b0);

    // Stream with a 3-cycle stall (garbage offered while ce=0)
    beat_all(16'sd1, 8'sd1, 1'b0, 1'b0, 1'b1, 32'sd1, 1'b0);
    beat_all(-16'sd2, 8'sd3, 1'b0, 1'b0, 1'b1, -32'sd6, 1'b0);
    beat_all(16'sd100, -8'sd100, 1'b0, 1'b0, 1'b1, -32'sd10000, 1'b0);
    idle(3, 1'b1, 1'b0);
    idle(3, 1'b0, 1'b1);
    beat_all(16'sd32767, 8'sd127, 1'b0, 1'b0, 1'b1, 32'sd4161409, 1'b0);
    beat_all(-16'sd32768, -8'sd128, 1'b0, 1'b0, 1'b1, 32'sd4194304, 1'b0);
    beat_all(-16'sd1, -8'sd1, 1'b0, 1'b0, 1'b1, 32'sd1, 1'b0);
    idle(10, 1'b1, 1'b0);

    // Reset mid-group with a multiply still in flight
    beat_all(16'sd3, 8'sd3, 1'b1, 1'b0, 1'b0, 32'sd0, 1'b0);
    beat_all(16'sd4, 8'sd4, 1'b1, 1'b0, 1'b0, 32'sd0, 1'b0);
    idle(8, 1'b1, 1'b0);
    beat_all(16'sd9, 8'sd9, 1'b0, 1'b0, 1'b0, 32'sd0, 1'b0);
    idle(1, 1'b1, 1'b0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    idle(2, 1'b1, 1'b0);
    beat_all(16'sd5, 8'sd5, 1'b1, 1'b1, 1'b1, 32'sd25, 1'b1);
    idle(12, 1'b1, 1'b0);

    chk(0, "leftover_expected", sb_q[0].size(), 0);
    chk(1, "leftover_expected", sb_q[1].size(), 0);
    chk(2, "leftover_expected", sb_q[2].size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
